uart_rx_oversampled: RTL
========================

Name: uart_rx_oversampled

Overview:
- Next-generation UART receive path: 16x-oversampled receiver with majority-vote bit sampling and a runtime-programmable baud divisor, so no fixed CLOCK_FREQ/BAUD_RATE pair is needed.
- Runtime frame format: 5-8 data bits, parity none/even/odd, 1 or 2 stop bits.
- Frames are stored with per-entry error flags in a first-word-fall-through FIFO.
- Sits between the pad-side rx line and the host/register interface.

Parameters:
- OVERSAMPLE, 16, ticks per bit; power of two, minimum 8
- DIV_WIDTH, 16, width of baud_div
- MAX_DATA_BITS, 8, width of rx_data; data_bits_sel selects 5..8
- FIFO_DEPTH, 16, entries; power of two, minimum 2
- CNT_WIDTH, 8, width of the error counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx  in  1  serial input, asynchronous to clk
- baud_div  in  DIV_WIDTH  oversample tick period minus one
- data_bits_sel  in  2  0=5, 1=6, 2=7, 3=8 data bits
- parity_enable  in  1  parity bit present
- parity_type  in  1  0=even, 1=odd
- stop_bits_sel  in  1  0=one stop bit, 1=two stop bits
- fifo_read  in  1  pop head entry
- clear_errors  in  1  zero counters and sticky overflow
- rx_data  out  MAX_DATA_BITS  head entry data, right-justified, upper bits zero
- rx_parity_err  out  1  parity error flag of head entry
- rx_frame_err  out  1  framing error flag of head entry
- rx_data_ready  out  1  equals !fifo_empty
- fifo_empty  out  1  FIFO holds no entries
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries
- rx_overflow_error  out  1  sticky: a frame was dropped
- parity_error_count  out  CNT_WIDTH  saturating count of parity errors
- framing_error_count  out  CNT_WIDTH  saturating count of framing errors

Behaviour:
- Reset: all outputs 0 except fifo_empty=1. Synchroniser flops reset to 1. State IDLE, FIFO pointers cleared. Reset mid-frame discards the frame.
- Synchroniser: rx passes through 2 flops; every FSM decision uses the synchronised value.
- Tick: a counter counts 0..baud_div and pulses tick when it wraps, giving one tick every baud_div+1 clocks (baud_div=0 ticks every clock). The counter free-runs while IDLE, and is re-zeroed when a start edge is detected.
- Config: data_bits_sel, parity_enable, parity_type and stop_bits_sel are latched at start detection. Changes mid-frame have no effect on the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a 1->0 transition of the synchronised rx moves to START.
  - Every state counts OVERSAMPLE ticks per bit. The bit value is the majority of the samples at ticks OS/2-1, OS/2 and OS/2+1.
  - START: if the vote is 1 (false start), return to IDLE. Otherwise, at tick OVERSAMPLE-1 go to DATA.
  - DATA: shifts LSB-first for N bits, then goes to PARITY if enabled, else STOP.
  - PARITY: parity error = (XOR of data bits XOR parity bit) != parity_type.
  - STOP: a vote of 0 sets the framing error; with two stop bits, either bit low sets it. At the mid-sample (tick OS/2+1) of the last stop bit the frame is pushed and the FSM returns to IDLE. This allows 0.5-bit resynchronisation.
- Counters: a counter increments once per frame carrying the corresponding error and saturates at all-ones. clear_errors zeroes both counters and rx_overflow_error; if an increment occurs in the same cycle, clear wins.
- FIFO:
  - Entry = {frame_err, parity_err, data}. Head entry is visible on the outputs while not empty.
  - Pop with fifo_read on a non-empty FIFO; fifo_read on empty is ignored.
  - Push while full with no pop: frame dropped, rx_overflow_error set, counters still updated.
  - Push and pop in the same cycle: both take effect, fifo_count unchanged; this applies when full as well.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined: a frame whose data, parity and stop bits are all 0 is a break. It is not pushed to the FIFO and does not increment the counters. A sticky break_detected output (1 bit, cleared by clear_errors) is set. The FSM then waits for rx to be high for a full bit time before returning to IDLE.
- Undefined: the port is absent. The same frame is pushed as data 0 with frame_err=1 and counts as a framing error.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum;
  - data_bits_sel encodings;
  - the FIFO entry struct;
  - a function computing the data-bit count.
- One sub-module, uart_rx_fifo: parametrised FWFT FIFO with count, full and empty outputs.
- The tick generator and FSM stay inline.

Test Plan:
- Reset, then 8N1 frame 0xA5 (baud_div=0): after the stop mid-sample, fifo_count=1, rx_data=0xA5, both error flags 0.
- 7E2 frame with wrong parity for 0x3C: rx_data=0x3C, rx_parity_err=1, parity_error_count=1. A second bad frame gives 2.
- 5N1 frame 0x15 with stop bit low: rx_data=0x15, rx_frame_err=1, framing_error_count=1. Upper data bits read 0.
- Send 17 frames with FIFO_DEPTH=16 and no reads: fifo_full=1, rx_overflow_error=1, the first 16 frames intact. Then clear_errors: counters and overflow go to 0.
- Pop in the same cycle as a push while full: fifo_count stays 16 and data order is preserved. A 1-tick low glitch on rx in IDLE (false start) pushes no frame.
- Assert rst mid-DATA: all outputs return to reset values. The next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared types for the oversampled UART receiver:
//   - rx_state_t      : receiver FSM states
//   - DBITS_*         : data_bits_sel encodings
//   - rx_entry_t      : FIFO entry {frame_err, parity_err, data}
//   - data_bits_count : maps data_bits_sel to a data-bit count
//   - maj3            : three-sample majority vote
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    // Widest frame the format selector can describe; the data field is sized to it
    // and the top resizes it to MAX_DATA_BITS on the way out.
    localparam int ENTRY_DATA_W = 8;

    typedef struct packed {
        logic                    frame_err;
        logic                    parity_err;
        logic [ENTRY_DATA_W-1:0] data;
    } rx_entry_t;

    function automatic logic [3:0] data_bits_count(input logic [1:0] sel);
        case (sel)
            DBITS_5: return 4'd5;
            DBITS_6: return 4'd6;
            DBITS_7: return 4'd7;
            DBITS_8: return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through FIFO: the head entry is presented on rdata_o while
// the FIFO is not empty (zero when empty). A push while full is accepted only
// if a pop happens in the same cycle.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i (ignored when full without a pop)
//   wdata_i   : entry to store
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : head entry
//   empty_o   : no entries stored
//   full_o    : DEPTH entries stored
//   count_o   : number of stored entries
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot that a same-cycle push needs when full.
    assign do_push = push_i && (!full_o || do_pop);

    // Power-of-two depth: pointers wrap by natural overflow.
    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign count_d  = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_oversampled.sv
// -----------------------------------------------------------------------------
// uart_rx_oversampled
// 16x (OVERSAMPLE) oversampled UART receiver with majority-vote sampling,
// runtime baud divisor and frame format, error counters and an FWFT FIFO.
// Optional build macro UART_RX_BREAK_DETECT_EN: all-zero frames are treated as
// a line break (not stored, not counted) and reported on break_detected.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   rx                   : serial input (asynchronous, synchronised inside)
//   baud_div             : oversample tick period minus one
//   data_bits_sel        : 0..3 -> 5..8 data bits
//   parity_enable        : parity bit present
//   parity_type          : 0 even, 1 odd
//   stop_bits_sel        : 0 one stop bit, 1 two stop bits
//   fifo_read            : pop head entry
//   clear_errors         : zero counters and sticky flags
//   rx_data              : head data, right-justified
//   rx_parity_err        : head parity error flag
//   rx_frame_err         : head framing error flag
//   rx_data_ready        : FIFO not empty
//   fifo_empty/full/count: FIFO status
//   rx_overflow_error    : sticky, a frame was dropped
//   parity_error_count   : saturating parity error count
//   framing_error_count  : saturating framing error count
//   break_detected       : sticky break flag (macro builds only)
// -----------------------------------------------------------------------------
module uart_rx_oversampled
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int DIV_WIDTH     = 16,
    parameter int MAX_DATA_BITS = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic [1:0]                    data_bits_sel,
    input  logic                          parity_enable,
    input  logic                          parity_type,
    input  logic                          stop_bits_sel,
    input  logic                          fifo_read,
    input  logic                          clear_errors,
    output logic [MAX_DATA_BITS-1:0]      rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_data_ready,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_overflow_error,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                          break_detected,
`endif
    output logic [CNT_WIDTH-1:0]          parity_error_count,
    output logic [CNT_WIDTH-1:0]          framing_error_count
);

    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(MAX_DATA_BITS);
    localparam logic [OS_W-1:0] T_S0   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] T_S1   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] T_S2   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0] T_LAST = OS_W'(OVERSAMPLE - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Synchroniser and edge history; idle line level is 1.
    logic [1:0] sync_q;
    logic       rx_prev_q;
    logic       rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= sync_q[1];
        end
    end

    assign rx_s = sync_q[1];

    rx_state_t state_q;
    logic      start_det;

    assign start_det = (state_q == ST_IDLE) && rx_prev_q && !rx_s;

    // Oversample tick; >= keeps it wrapping if baud_div is lowered mid-count.
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic                 tick;

    assign tick = (div_cnt_q >= baud_div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else if (start_det || tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // Receiver FSM and frame datapath.
    logic [OS_W-1:0]          os_cnt_q;
    logic [IDX_W-1:0]         bit_idx_q;
    logic                     stop_idx_q;
    logic [1:0]               samp_q;
    logic [MAX_DATA_BITS-1:0] data_q;
    logic                     par_err_q;
    logic                     frame_err_q;
    logic [3:0]               nbits_q;
    logic                     par_en_q;
    logic                     par_type_q;
    logic                     two_stop_q;
    logic                     push_q;
    rx_entry_t                push_entry_q;
    logic                     vote;
    logic                     fe_now;

    assign vote   = maj3(samp_q[0], samp_q[1], rx_s);
    assign fe_now = frame_err_q | ~vote;

`ifdef UART_RX_BREAK_DETECT_EN
    logic par_bit_q;
    logic stop_high_q;
    logic break_q;
    logic is_break;

    assign is_break       = (data_q == '0) && !par_bit_q && !stop_high_q && !vote;
    assign break_detected = break_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            os_cnt_q     <= '0;
            bit_idx_q    <= '0;
            stop_idx_q   <= 1'b0;
            samp_q       <= 2'b11;
            data_q       <= '0;
            par_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            nbits_q      <= 4'd8;
            par_en_q     <= 1'b0;
            par_type_q   <= 1'b0;
            two_stop_q   <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
            par_bit_q    <= 1'b0;
            stop_high_q  <= 1'b0;
            break_q      <= 1'b0;
`endif
        end else begin
            push_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (start_det) begin
                    state_q     <= ST_START;
                    os_cnt_q    <= '0;
                    bit_idx_q   <= '0;
                    stop_idx_q  <= 1'b0;
                    data_q      <= '0;
                    par_err_q   <= 1'b0;
                    frame_err_q <= 1'b0;
                    nbits_q     <= data_bits_count(data_bits_sel);
                    par_en_q    <= parity_enable;
                    par_type_q  <= parity_type;
                    two_stop_q  <= stop_bits_sel;
`ifdef UART_RX_BREAK_DETECT_EN
                    par_bit_q   <= 1'b0;
                    stop_high_q <= 1'b0;
`endif
                end
            end else if (tick) begin
                // Power-of-two OVERSAMPLE: the bit-phase counter wraps on its own.
                os_cnt_q <= os_cnt_q + 1'b1;
                if (os_cnt_q == T_S0) samp_q[0] <= rx_s;
                if (os_cnt_q == T_S1) samp_q[1] <= rx_s;
                case (state_q)
                    ST_START: begin
                        if (os_cnt_q == T_S2 && vote) begin
                            state_q <= ST_IDLE;
                        end else if (os_cnt_q == T_LAST) begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (os_cnt_q == T_S2) begin
                            data_q[bit_idx_q] <= vote;
                        end
                        if (os_cnt_q == T_LAST) begin
                            if (bit_idx_q == IDX_W'(nbits_q - 4'd1)) begin
                                state_q <= par_en_q ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (os_cnt_q == T_S2) begin
                            // Unused upper data bits are zero, so the full-width XOR is safe.
                            par_err_q <= ((^data_q) ^ vote) != par_type_q;
`ifdef UART_RX_BREAK_DETECT_EN
                            par_bit_q <= vote;
`endif
                        end
                        if (os_cnt_q == T_LAST) begin
                            state_q <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (os_cnt_q == T_S2) begin
                            frame_err_q <= fe_now;
`ifdef UART_RX_BREAK_DETECT_EN
                            if (vote) stop_high_q <= 1'b1;
`endif
                            // Finish at the middle of the last stop bit so the next start
                            // edge can be caught half a bit early.
                            if (stop_idx_q == two_stop_q) begin
`ifdef UART_RX_BREAK_DETECT_EN
                                if (is_break) begin
                                    break_q  <= 1'b1;
                                    state_q  <= ST_BREAK;
                                    os_cnt_q <= '0;
                                end else begin
                                    push_q                  <= 1'b1;
                                    push_entry_q.frame_err  <= fe_now;
                                    push_entry_q.parity_err <= par_err_q;
                                    push_entry_q.data       <= ENTRY_DATA_W'(data_q);
                                    state_q                 <= ST_IDLE;
                                end
`else
                                push_q                  <= 1'b1;
                                push_entry_q.frame_err  <= fe_now;
                                push_entry_q.parity_err <= par_err_q;
                                push_entry_q.data       <= ENTRY_DATA_W'(data_q);
                                state_q                 <= ST_IDLE;
`endif
                            end
                        end else if (os_cnt_q == T_LAST) begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        // Require a full bit time of continuous high line before re-arming.
                        if (!rx_s) begin
                            os_cnt_q <= '0;
                        end else if (os_cnt_q == T_LAST) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
`ifdef UART_RX_BREAK_DETECT_EN
            if (clear_errors) break_q <= 1'b0;
`endif
        end
    end

    // Frame FIFO.
    rx_entry_t head;
    logic      fifo_empty_w;
    logic      fifo_full_w;

    uart_rx_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .wdata_i (push_entry_q),
        .pop_i   (fifo_read),
        .rdata_o (head),
        .empty_o (fifo_empty_w),
        .full_o  (fifo_full_w),
        .count_o (fifo_count)
    );

    assign fifo_empty    = fifo_empty_w;
    assign fifo_full     = fifo_full_w;
    assign rx_data_ready = !fifo_empty_w;
    assign rx_data       = MAX_DATA_BITS'(head.data);
    assign rx_parity_err = head.parity_err;
    assign rx_frame_err  = head.frame_err;

    // Error counters and sticky overflow; clear takes priority over any update.
    logic [CNT_WIDTH-1:0] par_cnt_q;
    logic [CNT_WIDTH-1:0] frm_cnt_q;
    logic                 ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else if (clear_errors) begin
            par_cnt_q <= '0;
            frm_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (push_q && push_entry_q.parity_err) par_cnt_q <= sat_inc(par_cnt_q);
            if (push_q && push_entry_q.frame_err)  frm_cnt_q <= sat_inc(frm_cnt_q);
            if (push_q && fifo_full_w && !fifo_read) ovf_q <= 1'b1;
        end
    end

    assign parity_error_count  = par_cnt_q;
    assign framing_error_count = frm_cnt_q;
    assign rx_overflow_error   = ovf_q;

endmodule
